spi_slave_shifter: RTL

//  SPI target-side transceiver: the far end of our SPI master (slave select, baud, shift blocks).

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_shifter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, CPOL/CPHA bit positions, and the
// frame-sequencer state type.
package spi_pkg;

   localparam int DATA_W_DEF = 8;

   // Bit positions inside spi_mode_i = {CPOL, CPHA}
   localparam int CPOL_IDX = 1;
   localparam int CPHA_IDX = 0;

   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by an edge flop
// that turns level changes into single-PCLK rise/fall pulses.
module spi_sync_edge #(
   parameter int   SYNC_STG = 2,
   parameter logic RST_VAL  = 1'b0
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STG-1:0] sync_q;
   logic                edge_q;

   // NOTE: non-blocking assignments so every stage captures the value its
   // predecessor held before this edge; blocking would collapse the chain.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sync_q <= {SYNC_STG{RST_VAL}};
         edge_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], d};
         edge_q <= sync_q[SYNC_STG-1];
      end
   end

   assign q    = sync_q[SYNC_STG-1];
   assign rise = q & ~edge_q;
   assign fall = ~q & edge_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI target transceiver: oversamples SCLK/SS_n/MOSI in the PCLK domain and
// shifts DATA_W-bit frames. Define SPI_SLV_LSBFE_EN to add the lsbfe_i port.
module spi_slave_shifter
   import spi_pkg::*;
#(
   parameter int                DATA_W    = DATA_W_DEF,
   parameter int                SYNC_STG  = 2,
   parameter logic [DATA_W-1:0] IDLE_FILL = {DATA_W{1'b1}}
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              spe_i,
   input  logic [1:0]        spi_mode_i,
`ifdef SPI_SLV_LSBFE_EN
   input  logic              lsbfe_i,
`endif
   input  logic              sclk_i,
   input  logic              ss_n_i,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              tx_undr_o,
   output logic              frame_err_o
);

   localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

   logic sclk_q, sclk_rise, sclk_fall;
   logic ss_q, ss_fall, ss_rise_unused;
   logic mosi_q, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sclk_sync (
      .PCLK(PCLK), .PRESET(PRESET), .d(sclk_i),
      .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );

   // Deselected is the safe power-up assumption for slave select.
   spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_ss_sync (
      .PCLK(PCLK), .PRESET(PRESET), .d(ss_n_i),
      .q(ss_q), .rise(ss_rise_unused), .fall(ss_fall)
   );

   spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_mosi_sync (
      .PCLK(PCLK), .PRESET(PRESET), .d(mosi_i),
      .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_state_e        state, state_nxt;
   logic [1:0]        mode_q;
   logic              lsb_first;
   logic [DATA_W-1:0] tx_buf, tx_shift, rx_shift, rx_word, load_word;
   logic              tx_full;
   logic [CNT_W-1:0]  bit_cnt;
   logic              miso_q, miso_oe_q, rx_valid_q, tx_undr_q, frame_err_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              lead_edge, trail_edge, sample_edge, shift_edge;
   logic              frame_done, frame_abort;

   function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                  input logic lsb);
      return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
   endfunction

   // SCLK polarity and phase pick which synced edge samples and which shifts.
   assign lead_edge   = mode_q[CPOL_IDX] ? sclk_fall : sclk_rise;
   assign trail_edge  = mode_q[CPOL_IDX] ? sclk_rise : sclk_fall;
   assign sample_edge = mode_q[CPHA_IDX] ? trail_edge : lead_edge;
   assign shift_edge  = mode_q[CPHA_IDX] ? lead_edge : trail_edge;
   assign rx_word     = shift_in(rx_shift, mosi_q, lsb_first);
   assign load_word   = tx_full ? tx_buf : IDLE_FILL;

   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      frame_done  = 1'b0;
      frame_abort = 1'b0;
      unique case (state)
         IDLE:  if (spe_i && ss_fall) state_nxt = LOAD;
         LOAD:  state_nxt = SHIFT;
         SHIFT: begin
            if (sample_edge && bit_cnt == LAST_BIT) begin
               frame_done = 1'b1;
               state_nxt  = ss_q ? IDLE : LOAD;
            end else if (ss_q) begin
               frame_abort = (bit_cnt != '0) || sample_edge;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!spe_i) begin
         state_nxt   = IDLE;
         frame_done  = 1'b0;
         frame_abort = 1'b0;
      end
   end

   // NOTE: tx_buf holds data only; tx_full qualifies it, so the data
   // register is deliberately left out of reset.
   always_ff @(posedge PCLK) begin
      if (tx_valid_i && !tx_full) tx_buf <= tx_data_i;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         mode_q      <= MODE0;
         tx_full     <= 1'b0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         bit_cnt     <= '0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_undr_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_valid_q  <= frame_done;
         frame_err_q <= frame_abort;
         tx_undr_q   <= 1'b0;
         miso_oe_q   <= spe_i & ~ss_q;
         if (state == IDLE) mode_q <= spi_mode_i;
         if (spe_i) begin
            unique case (state)
               LOAD: begin
                  tx_undr_q <= ~tx_full;
                  tx_full   <= 1'b0;
                  bit_cnt   <= '0;
                  rx_shift  <= '0;
                  // CPHA=0 must present bit0 before the first leading edge.
                  if (!mode_q[CPHA_IDX]) begin
                     miso_q   <= first_bit(load_word, lsb_first);
                     tx_shift <= shift_out(load_word, lsb_first);
                  end else begin
                     tx_shift <= load_word;
                  end
               end
               SHIFT: begin
                  // A CPHA=0 trailing edge before any sample belongs to the previous frame.
                  if (shift_edge && (mode_q[CPHA_IDX] || bit_cnt != '0)) begin
                     miso_q   <= first_bit(tx_shift, lsb_first);
                     tx_shift <= shift_out(tx_shift, lsb_first);
                  end
                  if (sample_edge) begin
                     rx_shift <= rx_word;
                     bit_cnt  <= bit_cnt + CNT_W'(1);
                  end
                  if (frame_done) rx_data_q <= rx_word;
               end
               default: ;
            endcase
         end
         // Placed after LOAD so a write landing in the LOAD cycle is kept.
         if (tx_valid_i && !tx_full) tx_full <= 1'b1;
      end
   end

`ifdef SPI_SLV_LSBFE_EN
   logic lsbfe_q;
   always_ff @(posedge PCLK) begin
      if (PRESET)             lsbfe_q <= 1'b0;
      else if (state == IDLE) lsbfe_q <= lsbfe_i;
   end
   assign lsb_first = lsbfe_q;
`else
   assign lsb_first = 1'b0;
`endif

   assign miso_o      = miso_q;
   assign miso_oe_o   = miso_oe_q;
   assign tx_ready_o  = ~tx_full;
   assign rx_data_o   = rx_data_q;
   assign rx_valid_o  = rx_valid_q;
   assign tx_undr_o   = tx_undr_q;
   assign frame_err_o = frame_err_q;

endmodule
